// File: rtl/pia_pkg.sv
// Shared constants for the pia_riot RIOT block: register map, prescaler defaults,
// INSTAT bit positions and the timer select encoding.
package pia_pkg;

    localparam logic [6:0] ADR_SWCHA  = 7'h00;
    localparam logic [6:0] ADR_SWACNT = 7'h01;
    localparam logic [6:0] ADR_SWCHB  = 7'h02;
    localparam logic [6:0] ADR_SWBCNT = 7'h03;
    localparam logic [6:0] ADR_INTIM  = 7'h04;
    localparam logic [6:0] ADR_INSTAT = 7'h05;

    // Edge control occupies 0x04..0x07 on writes; timer loads 0x14..0x17 and 0x1C..0x1F.
    localparam logic [6:0] ADR_EDGE   = 7'h04;
    localparam logic [6:0] ADR_TIM    = 7'h14;
    localparam int         TIM_IE_BIT = 3;

    localparam int PRESC0_LOG2_DEF = 0;
    localparam int PRESC1_LOG2_DEF = 3;
    localparam int PRESC2_LOG2_DEF = 6;
    localparam int PRESC3_LOG2_DEF = 10;

    localparam int INSTAT_TFLAG = 7;
    localparam int INSTAT_PFLAG = 6;

    typedef enum logic [1:0] {
        SEL_TIM1T  = 2'd0,
        SEL_TIM8T  = 2'd1,
        SEL_TIM64T = 2'd2,
        SEL_T1024T = 2'd3
    } tim_sel_e;

    // Prescaler width: widest of the four divides, never narrower than one bit.
    function automatic int presc_width(input int a, input int b, input int c, input int d);
        int w;
        w = 1;
        if (a > w) w = a;
        if (b > w) w = b;
        if (c > w) w = c;
        if (d > w) w = d;
        return w;
    endfunction

endpackage

// File: rtl/pia_riot_if.sv
// CPU-side register bus of the RIOT: strobe, direction, address, write data and
// registered read data.
interface pia_riot_if;
    logic       stb_i;
    logic       we_i;
    logic [6:0] adr_i;
    logic [7:0] dat_i;
    logic [7:0] dat_o;

    modport master (output stb_i, we_i, adr_i, dat_i, input dat_o);
    modport slave  (input stb_i, we_i, adr_i, dat_i, output dat_o);
endinterface

// File: rtl/pia_riot_timer.sv
// Interval timer: prescaler, INTIM down-counter, rate select and timer flag.
// Counts only in tick_i cycles and only after the first load following reset.
module pia_riot_timer
    import pia_pkg::*;
#(
    parameter int PRESC0_LOG2 = PRESC0_LOG2_DEF,
    parameter int PRESC1_LOG2 = PRESC1_LOG2_DEF,
    parameter int PRESC2_LOG2 = PRESC2_LOG2_DEF,
    parameter int PRESC3_LOG2 = PRESC3_LOG2_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       load_i,
    input  tim_sel_e   sel_i,
    input  logic [7:0] dat_i,
    input  logic       rd_clr_i,
    output logic [7:0] value_o,
    output logic       flag_o
);

    localparam int PW = presc_width(PRESC0_LOG2, PRESC1_LOG2, PRESC2_LOG2, PRESC3_LOG2);

    localparam logic [PW-1:0] MASK0 = PW'((1 << PRESC0_LOG2) - 1);
    localparam logic [PW-1:0] MASK1 = PW'((1 << PRESC1_LOG2) - 1);
    localparam logic [PW-1:0] MASK2 = PW'((1 << PRESC2_LOG2) - 1);
    localparam logic [PW-1:0] MASK3 = PW'((1 << PRESC3_LOG2) - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] mask_q;     // terminal count of the active rate; 0 means one per tick
    logic [PW-1:0] mask_sel;
    logic [7:0]    intim_q;
    logic          flag_q;
    logic          active_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mask_sel = MASK3;
        case (sel_i)
            SEL_TIM1T:  mask_sel = MASK0;
            SEL_TIM8T:  mask_sel = MASK1;
            SEL_TIM64T: mask_sel = MASK2;
            SEL_T1024T: mask_sel = MASK3;
            default:    mask_sel = MASK3;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            mask_q   <= MASK3;
            intim_q  <= '0;
            flag_q   <= 1'b0;
            active_q <= 1'b0;
        end else if (load_i) begin
            presc_q  <= '0;
            mask_q   <= mask_sel;
            intim_q  <= dat_i;
            flag_q   <= 1'b0;
            active_q <= 1'b1;
        end else begin
            if (rd_clr_i) begin
                flag_q <= 1'b0;
            end
            // A wrap in the same cycle as the INTIM read overrides the clear above.
            if (tick_i && active_q) begin
                if (presc_q == mask_q) begin
                    presc_q <= '0;
                    intim_q <= intim_q - 8'd1;
                    if (intim_q == 8'd0) begin
                        flag_q <= 1'b1;
                        mask_q <= '0;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    assign value_o = intim_q;
    assign flag_o  = flag_q;

endmodule

// File: rtl/pia_riot.sv
// 6532-style RIOT: two ports with data-direction registers, interval timer,
// PA7 edge detector and combined active-low interrupt.
// Optional: define PIA_INPUT_SYNC_EN to pass pa_i/pb_i through 2-flop synchronisers.
module pia_riot
    import pia_pkg::*;
#(
    parameter int PORT_W      = 8,
    parameter int PRESC0_LOG2 = PRESC0_LOG2_DEF,
    parameter int PRESC1_LOG2 = PRESC1_LOG2_DEF,
    parameter int PRESC2_LOG2 = PRESC2_LOG2_DEF,
    parameter int PRESC3_LOG2 = PRESC3_LOG2_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tick_i,
    pia_riot_if.slave         bus,
    input  logic [PORT_W-1:0] pa_i,
    output logic [PORT_W-1:0] pa_o,
    output logic [PORT_W-1:0] pa_oe_o,
    input  logic [PORT_W-1:0] pb_i,
    output logic [PORT_W-1:0] pb_o,
    output logic [PORT_W-1:0] pb_oe_o,
    output logic              irq_no,
    output logic [7:0]        diag
);

    logic [PORT_W-1:0] ora_q, orb_q, ddra_q, ddrb_q;
    logic [PORT_W-1:0] pa_s, pb_s;
    logic [7:0]        dat_q, rd_data, intim;
    logic              pflag_q, pie_q, tie_q, edge_pos_q, pa7_q;
    logic              tflag, pa7, edge_hit;
    logic              wr, rd, rd_intim, rd_instat, tim_wr, edge_wr;

`ifdef PIA_INPUT_SYNC_EN
    logic [PORT_W-1:0] pa_m, pb_m;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pa_m <= '0;
            pb_m <= '0;
            pa_s <= '0;
            pb_s <= '0;
        end else begin
            pa_m <= pa_i;
            pb_m <= pb_i;
            pa_s <= pa_m;
            pb_s <= pb_m;
        end
    end
`else
    assign pa_s = pa_i;
    assign pb_s = pb_i;
`endif

    assign wr        = bus.stb_i &  bus.we_i;
    assign rd        = bus.stb_i & ~bus.we_i;
    assign rd_intim  = rd && (bus.adr_i == ADR_INTIM);
    assign rd_instat = rd && (bus.adr_i == ADR_INSTAT);
    assign edge_wr   = wr && (bus.adr_i[6:2] == ADR_EDGE[6:2]);
    assign tim_wr    = wr && (bus.adr_i[6:4] == ADR_TIM[6:4]) && (bus.adr_i[2] == ADR_TIM[2]);

    // Narrow ports have no PA7, so the edge detector sees a constant 0.
    assign pa7      = (PORT_W == 8) ? pa_s[PORT_W-1] : 1'b0;
    assign edge_hit = edge_pos_q ? (pa7 & ~pa7_q) : (~pa7 & pa7_q);

    pia_riot_timer #(
        .PRESC0_LOG2 (PRESC0_LOG2),
        .PRESC1_LOG2 (PRESC1_LOG2),
        .PRESC2_LOG2 (PRESC2_LOG2),
        .PRESC3_LOG2 (PRESC3_LOG2)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (tick_i),
        .load_i   (tim_wr),
        .sel_i    (tim_sel_e'(bus.adr_i[1:0])),
        .dat_i    (bus.dat_i),
        .rd_clr_i (rd_intim),
        .value_o  (intim),
        .flag_o   (tflag)
    );

    always_comb begin
        rd_data = '0;
        case (bus.adr_i)
            ADR_SWCHA:  rd_data = 8'((ora_q & ddra_q) | (pa_s & ~ddra_q));
            ADR_SWACNT: rd_data = 8'(ddra_q);
            ADR_SWCHB:  rd_data = 8'((orb_q & ddrb_q) | (pb_s & ~ddrb_q));
            ADR_SWBCNT: rd_data = 8'(ddrb_q);
            ADR_INTIM:  rd_data = intim;
            ADR_INSTAT: begin
                rd_data[INSTAT_TFLAG] = tflag;
                rd_data[INSTAT_PFLAG] = pflag_q;
            end
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ora_q      <= '0;
            orb_q      <= '0;
            ddra_q     <= '0;
            ddrb_q     <= '0;
            dat_q      <= '0;
            pflag_q    <= 1'b0;
            pie_q      <= 1'b0;
            tie_q      <= 1'b0;
            edge_pos_q <= 1'b0;
            pa7_q      <= 1'b0;
        end else begin
            pa7_q <= pa7;
            // A detected edge wins over a same-cycle INSTAT read.
            if (edge_hit) begin
                pflag_q <= 1'b1;
            end else if (rd_instat) begin
                pflag_q <= 1'b0;
            end
            if (wr && bus.adr_i == ADR_SWCHA)  ora_q  <= bus.dat_i[PORT_W-1:0];
            if (wr && bus.adr_i == ADR_SWACNT) ddra_q <= bus.dat_i[PORT_W-1:0];
            if (wr && bus.adr_i == ADR_SWCHB)  orb_q  <= bus.dat_i[PORT_W-1:0];
            if (wr && bus.adr_i == ADR_SWBCNT) ddrb_q <= bus.dat_i[PORT_W-1:0];
            if (edge_wr) begin
                edge_pos_q <= bus.adr_i[0];
                pie_q      <= bus.adr_i[1];
            end
            if (tim_wr) begin
                tie_q <= bus.adr_i[TIM_IE_BIT];
            end
            if (rd) begin
                dat_q <= rd_data;
            end
        end
    end

    assign bus.dat_o = dat_q;
    assign pa_o      = ora_q;
    assign pa_oe_o   = ddra_q;
    assign pb_o      = orb_q;
    assign pb_oe_o   = ddrb_q;
    assign irq_no    = ~((tflag & tie_q) | (pflag_q & pie_q));
    assign diag      = intim;

endmodule

// File: tb/tb_pia_riot.sv
// Directed self-checking bench for pia_riot: ports, timer rates, wrap and flags,
// PA7 edge interrupt and asynchronous reset mid-count.
module tb_pia_riot;
    import pia_pkg::*;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       tick_i = 1'b0;
    logic [7:0] pa_i, pa_o, pa_oe_o;
    logic [7:0] pb_i, pb_o, pb_oe_o;
    logic       irq_no;
    logic [7:0] diag;
    logic [7:0] rdat;

    int n_checks = 0;
    int n_errors = 0;

    pia_riot_if bus ();

    pia_riot #(.PORT_W(8)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tick_i  (tick_i),
        .bus     (bus),
        .pa_i    (pa_i),
        .pa_o    (pa_o),
        .pa_oe_o (pa_oe_o),
        .pb_i    (pb_i),
        .pb_o    (pb_o),
        .pb_oe_o (pb_oe_o),
        .irq_no  (irq_no),
        .diag    (diag)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic bus_wr(input logic [6:0] adr, input logic [7:0] dat);
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b1;
        bus.adr_i = adr;
        bus.dat_i = dat;
        step();
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic bus_rd(input logic [6:0] adr, output logic [7:0] dat);
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = adr;
        step();
        bus.stb_i = 1'b0;
        dat = bus.dat_o;
    endtask

    initial begin
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        pa_i = 8'h3C;
        pb_i = 8'hC6;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_dat_o", bus.dat_o, 8'h00);
        check("rst_irq",   8'(irq_no), 8'h01);
        check("rst_diag",  diag, 8'h00);
        check("rst_pa_o",  pa_o, 8'h00);
        check("rst_pa_oe", pa_oe_o, 8'h00);
        check("rst_pb_oe", pb_oe_o, 8'h00);
        rst_ni = 1'b1;
        step();
        bus_rd(7'h05, rdat);
        check("rst_instat", rdat, 8'h00);

        // Ports with mixed direction
        bus_wr(7'h01, 8'hF0);
        bus_wr(7'h00, 8'hA5);
        bus_wr(7'h03, 8'h0F);
        bus_wr(7'h02, 8'h33);
        bus_rd(7'h00, rdat);
        check("porta_rd", rdat, 8'hAC);
        check("pa_oe",    pa_oe_o, 8'hF0);
        check("pa_o",     pa_o, 8'hA5);
        bus_rd(7'h02, rdat);
        check("portb_rd", rdat, 8'hC3);
        bus_rd(7'h01, rdat);
        check("ddra_rd",  rdat, 8'hF0);
        bus_rd(7'h06, rdat);
        check("unmapped_rd", rdat, 8'h00);

        // TIM8T load of 2: eight ticks per step, wrap at tick 24
        bus_wr(7'h15, 8'h02);
        check("t8_load", diag, 8'h02);
        tick_i = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i == 7)  check("t8_tick7",  diag, 8'h02);
            if (i == 8)  check("t8_tick8",  diag, 8'h01);
            if (i == 15) check("t8_tick15", diag, 8'h01);
            if (i == 16) check("t8_tick16", diag, 8'h00);
            if (i == 23) check("t8_tick23", diag, 8'h00);
            if (i == 24) check("t8_tick24", diag, 8'hFF);
        end
        tick_i = 1'b0;
        check("t8_irq_masked", 8'(irq_no), 8'h01);
        bus_rd(7'h05, rdat);
        check("t8_instat", rdat, 8'h80);
        bus_rd(7'h05, rdat);
        check("t8_instat_keep", rdat, 8'h80);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        check("t8_fast", diag, 8'hFE);
        bus_rd(7'h04, rdat);
        check("t8_intim_rd", rdat, 8'hFE);
        bus_rd(7'h05, rdat);
        check("t8_tflag_clr", rdat, 8'h00);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        check("t8_still_fast", diag, 8'hFD);

        // TIM1T with interrupt, load 0
        bus_wr(7'h1C, 8'h00);
        check("t1_load", diag, 8'h00);
        check("t1_irq_idle", 8'(irq_no), 8'h01);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        check("t1_wrap", diag, 8'hFF);
        check("t1_irq_low", 8'(irq_no), 8'h00);
        bus_rd(7'h04, rdat);
        check("t1_intim_rd", rdat, 8'hFF);
        check("t1_irq_rise", 8'(irq_no), 8'h01);
        tick_i = 1'b1;
        step();
        check("t1_cont1", diag, 8'hFE);
        step();
        check("t1_cont2", diag, 8'hFD);
        tick_i = 1'b0;

        // Wrap and INTIM read in the same cycle: read sees 0, flag survives
        bus_wr(7'h14, 8'h00);
        tick_i    = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = 7'h04;
        step();
        bus.stb_i = 1'b0;
        tick_i    = 1'b0;
        check("race_rd", bus.dat_o, 8'h00);
        check("race_diag", diag, 8'hFF);
        bus_rd(7'h05, rdat);
        check("race_flag", rdat, 8'h80);

        // TIM1T load 5 with tick pulsed one cycle in four
        bus_wr(7'h14, 8'h05);
        for (int c = 1; c <= 20; c++) begin
            tick_i = (c % 4 == 0);
            step();
            if (c == 3)  check("pulse_c3",  diag, 8'h05);
            if (c == 4)  check("pulse_c4",  diag, 8'h04);
            if (c == 19) check("pulse_c19", diag, 8'h01);
            if (c == 20) check("pulse_c20", diag, 8'h00);
        end
        tick_i = 1'b0;

        // PA7 rising edge with interrupt enabled
        bus_wr(7'h07, 8'h00);
        pa_i = 8'hBC;
        repeat (3) step();
        check("edge_irq", 8'(irq_no), 8'h00);
        bus_rd(7'h05, rdat);
        check("edge_instat", rdat, 8'h40);
        check("edge_irq_clr", 8'(irq_no), 8'h01);
        bus_rd(7'h05, rdat);
        check("edge_instat_clr", rdat, 8'h00);
        pa_i = 8'h3C;
        repeat (3) step();
        check("fall_irq", 8'(irq_no), 8'h01);
        bus_rd(7'h05, rdat);
        check("fall_instat", rdat, 8'h00);

        // Reset in the middle of a count with a read pending
        pa_i = 8'hBC;
        repeat (3) step();
        check("pre_rst_irq", 8'(irq_no), 8'h00);
        bus_rd(7'h01, rdat);
        check("pre_rst_rd", rdat, 8'hF0);
        bus_wr(7'h1D, 8'h03);
        tick_i = 1'b1;
        repeat (5) step();
        check("pre_rst_diag", diag, 8'h03);
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = 7'h01;
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_dat_o", bus.dat_o, 8'h00);
        check("mid_rst_irq",   8'(irq_no), 8'h01);
        check("mid_rst_diag",  diag, 8'h00);
        check("mid_rst_pa_oe", pa_oe_o, 8'h00);
        @(negedge clk_i);
        bus.stb_i = 1'b0;
        rst_ni    = 1'b1;
        repeat (1100) step();
        check("post_rst_diag", diag, 8'h00);
        check("post_rst_irq",  8'(irq_no), 8'h01);
        bus_rd(7'h05, rdat);
        check("post_rst_instat", rdat, 8'h00);
        tick_i = 1'b0;
        bus_wr(7'h14, 8'h03);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        check("reload_count", diag, 8'h02);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
